nbit_regfile_sb: RTL
====================

# nbit_regfile_sb

Parametrised successor to the N-bit register file: a 2-read/1-write register file with configurable width and depth, an optional hardwired-zero register, same-cycle write-to-read bypass, and a per-register busy scoreboard for the pipeline's hazard unit. It replaces the single-cycle bulk reset with a sequential sweep-clear state machine, which lowers reset fan-out, and it reports readiness to the core. It sits between decode (reads and issue), writeback (writes) and the hazard/stall logic.

## Interface
- N, 32, data width in bits
- AW, 5, address width; DEPTH = 2**AW registers
- ZERO_REG, 1, when 1, register 0 always reads 0, is never written and is never busy
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, synchronous and active-high
- RegWrite  in  1  write enable (writeback)
- WriteAddress  in  AW  write address
- writeData  in  N  write data
- RegRead1, RegRead2  in  AW  read addresses
- IssueEn  in  1  an instruction with destination IssueAddress is issued this cycle
- IssueAddress  in  AW  destination register of the issued instruction
- RegReadOut1, RegReadOut2  out  N  read data (combinational)
- Busy1, Busy2  out  1  the addressed register has an outstanding write (combinational)
- Ready  out  1  the sweep-clear has finished and the block accepts traffic

## Operation
- States: CLEAR and RUN. A clock edge with rst=1 puts the block in CLEAR, sets ptr=0 and clears all busy bits. Register contents are not touched on that edge.
- CLEAR: on each edge with rst=0, write 0 to reg[ptr] and increment ptr. The edge that clears entry DEPTH-1 moves the block to RUN. While in CLEAR, RegWrite and IssueEn are ignored.
- RUN: on each edge with RegWrite=1 and a writable address, write reg[WriteAddress] <= writeData. An address is not writable when ZERO_REG=1 and the address is 0.
- Read path, evaluated independently for each port:
  - Not Ready: output 0.
  - ZERO_REG=1 and address 0: output 0.
  - Bypass case (RegWrite=1, WriteAddress == read address, address writable): output writeData.
  - Otherwise: output reg[address].
- Scoreboard, RUN only:
  - IssueEn sets busy[IssueAddress].
  - RegWrite clears busy[WriteAddress].
  - Same address set and cleared on the same edge: set wins, because the issue is the younger instruction.
  - Address 0 with ZERO_REG=1 is never set.
- BusyX = Ready and busy[RegReadX], and not (RegWrite and WriteAddress == RegReadX). A register being written this cycle is bypassed, so it is not reported as busy.
- Only one outstanding write per register is supported. A second issue to an already-busy register keeps it busy. Stalling on that case is the hazard unit's job.
- Width rules: ptr is AW+1 bits wide so it does not wrap during the sweep. Address comparisons use the full AW bits.

## Timing
- Reset values: Ready=0, Busy1=Busy2=0, RegReadOut1=RegReadOut2=0. This holds from the first edge with rst=1 until RUN.
- Sweep latency: with rst sampled high at edge 0 and low from edge 1 onward, Ready rises after edge DEPTH. For AW=5 that is edge 32.
- rst=1 mid-sweep or in RUN: on that edge the block returns to CLEAR with ptr=0, and the full DEPTH-cycle sweep restarts once rst falls.
- Reads and Busy outputs: zero-cycle combinational paths from the addresses, RegWrite, WriteAddress and writeData.
- Write-to-read latency: 0 cycles through the bypass; data is in the array from the following cycle.
- Issue to busy: busy is visible the cycle after the IssueEn edge. Writeback clears Busy in the same cycle combinationally and in the busy array from the next cycle.

## Test plan
- Reset sweep: hold rst for 3 cycles, then release. Ready=0 and reads=0 for 32 cycles; Ready=1 after the 32nd edge. Reading any register then returns 0.
- Reset mid-sweep: assert rst at sweep cycle 10, release after 1 cycle. Ready rises exactly 32 edges after the release.
- Write/read and bypass: in RUN, write 0xDEADBEEF to x5 while RegRead1=5. RegReadOut1=0xDEADBEEF in the same cycle and on later cycles. Write 0x1234 to x0 (ZERO_REG=1): reads of x0 stay 0.
- Scoreboard: issue dest x7, then RegRead2=7 gives Busy2=1 from the next cycle. Writeback to x7 with 0x55 gives Busy2=0 and RegReadOut2=0x55 in that same cycle, and Busy2 stays 0 afterwards.
- Set/clear collision: on one edge issue x9 and write back x9 with 0xAA. Afterwards Busy1=1 for RegRead1=9 and the read returns 0xAA.
- Traffic ignored during CLEAR: during the sweep drive IssueEn on x3 and RegWrite of 0xFF to x3. After Ready, x3 reads 0 and Busy=0.

Source files
------------

// File: rtl/nbit_regfile_sb.sv
// 2-read/1-write register file with a sweep-clear reset, same-cycle write bypass
// and a per-register busy scoreboard for the hazard unit.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_CLEAR | sweep writes 0 to reg[ptr] each cycle; traffic ignored
// ST_RUN   | normal operation, Ready=1, writes/issues accepted
module nbit_regfile_sb #(
    parameter int unsigned N        = 32,
    parameter int unsigned AW       = 5,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          RegWrite,
    input  logic [AW-1:0] WriteAddress,
    input  logic [N-1:0]  writeData,
    input  logic [AW-1:0] RegRead1,
    input  logic [AW-1:0] RegRead2,
    input  logic          IssueEn,
    input  logic [AW-1:0] IssueAddress,
    output logic [N-1:0]  RegReadOut1,
    output logic [N-1:0]  RegReadOut2,
    output logic          Busy1,
    output logic          Busy2,
    output logic          Ready
);

    localparam int unsigned DEPTH = 2 ** AW;
    localparam logic [AW:0] LAST_PTR = (AW + 1)'(DEPTH - 1);

    typedef enum logic {ST_CLEAR, ST_RUN} state_t;

    state_t            state_q, state_d;
    logic [AW:0]       ptr_q, ptr_d;
    logic [DEPTH-1:0]  busy_q, busy_d;
    logic [N-1:0]      mem_q [DEPTH];

    logic              mem_we;
    logic [AW-1:0]     mem_waddr;
    logic [N-1:0]      mem_wdata;

    logic zero_w, zero_i, zero_r1, zero_r2;
    logic wr_ok, hit1, hit2;

    assign zero_w  = (ZERO_REG != 0) && (WriteAddress == '0);
    assign zero_i  = (ZERO_REG != 0) && (IssueAddress == '0);
    assign zero_r1 = (ZERO_REG != 0) && (RegRead1 == '0);
    assign zero_r2 = (ZERO_REG != 0) && (RegRead2 == '0);

    assign Ready = (state_q == ST_RUN);
    assign wr_ok = RegWrite && !zero_w;
    assign hit1  = wr_ok && (WriteAddress == RegRead1);
    assign hit2  = wr_ok && (WriteAddress == RegRead2);

    assign RegReadOut1 = (!Ready || zero_r1) ? '0 : (hit1 ? writeData : mem_q[RegRead1]);
    assign RegReadOut2 = (!Ready || zero_r2) ? '0 : (hit2 ? writeData : mem_q[RegRead2]);

    // A register being written this cycle is bypassed, so it is not a hazard.
    assign Busy1 = Ready && busy_q[RegRead1] && !(RegWrite && (WriteAddress == RegRead1));
    assign Busy2 = Ready && busy_q[RegRead2] && !(RegWrite && (WriteAddress == RegRead2));

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        busy_d    = busy_q;
        mem_we    = 1'b0;
        mem_waddr = WriteAddress;
        mem_wdata = writeData;
        unique case (state_q)
            ST_CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = ptr_q[AW-1:0];
                mem_wdata = '0;
                ptr_d     = ptr_q + 1'b1;
                if (ptr_q == LAST_PTR) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                mem_we = wr_ok;
                if (RegWrite) begin
                    busy_d[WriteAddress] = 1'b0;
                end
                // Set after clear: the issuing instruction is the younger one.
                if (IssueEn && !zero_i) begin
                    busy_d[IssueAddress] = 1'b1;
                end
            end
            default: state_d = ST_CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_CLEAR;
            ptr_q   <= '0;
            busy_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            busy_q  <= busy_d;
        end
    end

    // Array contents are left alone on a reset edge; the sweep clears them.
    always_ff @(posedge clk) begin
        if (!rst && mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

endmodule
